// File: rtl/bram_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : bram_pkg
//  Description : Shared BRAM row geometry, stream element width, loader
//                state encoding and element-count clip limit.
//  Revision    : 1.0 - initial release
// ============================================================================
package bram_pkg;

    localparam int AWIDTH        = 8;
    localparam int DWIDTH        = 32;
    localparam int IN_DATA_WIDTH = 8;
    localparam int LANES         = DWIDTH / IN_DATA_WIDTH;

    // Largest element count that fits in BRAM0 (LANES elements per row).
    localparam int CLIP_LIMIT    = LANES << AWIDTH;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/lane_packer.sv
`default_nettype none
// ============================================================================
//  Module      : lane_packer
//  Description : Packs stream elements into a row buffer, first element in
//                the low lane. Flags a completed row when the top lane fills
//                or the final element arrives, then clears the buffer so a
//                trailing partial row is zero-padded.
//  Revision    : 1.0 - initial release
// ============================================================================
module lane_packer
    import bram_pkg::*;
#(
    parameter int P_DWIDTH        = DWIDTH,
    parameter int P_IN_DATA_WIDTH = IN_DATA_WIDTH
)(
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       i_clear,
    input  logic                       i_accept,
    input  logic                       i_last,
    input  logic [P_IN_DATA_WIDTH-1:0] i_data,
    output logic                       o_row_done,
    output logic [P_DWIDTH-1:0]        o_row_data
);

    localparam int P_LANES = P_DWIDTH / P_IN_DATA_WIDTH;
    localparam int LANE_W  = $clog2(P_LANES);

    logic [LANE_W-1:0]   r_lane;
    logic [P_DWIDTH-1:0] r_buf;
    logic [P_DWIDTH-1:0] w_row;
    logic                w_row_done;

    // Row as it looks with the element being accepted this cycle merged in.
    always_comb begin
        w_row = r_buf;
        if (i_accept) begin
            w_row[r_lane*P_IN_DATA_WIDTH +: P_IN_DATA_WIDTH] = i_data;
        end
    end

    assign w_row_done = i_accept && ((r_lane == LANE_W'(P_LANES - 1)) || i_last);
    assign o_row_done = w_row_done;
    assign o_row_data = w_row;

    // Lane pointer and buffer; both restart from zero after each row leaves.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_lane <= '0;
            r_buf  <= '0;
        end else if (i_clear) begin
            r_lane <= '0;
            r_buf  <= '0;
        end else if (i_accept) begin
            if (w_row_done) begin
                r_lane <= '0;
                r_buf  <= '0;
            end else begin
                r_lane <= r_lane + 1'b1;
                r_buf  <= w_row;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/bram0_loader.sv
`default_nettype none
// ============================================================================
//  Module      : bram0_loader
//  Description : Stream-to-BRAM0 writer. Accepts elements over valid/ready,
//                packs LANES per row and writes rows from address 0 upward.
//                Optional feature macro: BRAM0_LOADER_CHECKSUM_EN adds the
//                per-lane 16-bit element sums on checksum_o.
//  Revision    : 1.0 - initial release
// ============================================================================
module bram0_loader
    import bram_pkg::*;
#(
    parameter int CNT_BIT = 31
)(
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     start_i,
    input  logic [CNT_BIT-1:0]       load_count_i,
    input  logic                     s_valid_i,
    input  logic [IN_DATA_WIDTH-1:0] s_data_i,
    output logic                     s_ready_o,
    output logic                     idle_o,
    output logic                     run_o,
    output logic                     done_o,
    output logic [AWIDTH-1:0]        addr_b0_o,
    output logic                     ce_b0_o,
    output logic                     we_b0_o,
    output logic [DWIDTH-1:0]        d_b0_o
`ifdef BRAM0_LOADER_CHECKSUM_EN
    ,
    output logic [LANES*2*IN_DATA_WIDTH-1:0] checksum_o
`endif
);

    // Element counter must hold the clip limit itself.
    localparam int CNT_W = $clog2(CLIP_LIMIT) + 1;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_count;
    logic [CNT_W-1:0]   r_elem_cnt;
    logic [CNT_W-1:0]   w_count_clip;
    logic [AWIDTH-1:0]  r_row_cnt;
    logic [AWIDTH-1:0]  r_addr;
    logic [DWIDTH-1:0]  r_data;
    logic               r_ce;
    logic               w_start;
    logic               w_ready;
    logic               w_accept;
    logic               w_last;
    logic               w_row_done;
    logic [DWIDTH-1:0]  w_row_data;

    assign w_count_clip = (load_count_i > CNT_BIT'(CLIP_LIMIT)) ? CNT_W'(CLIP_LIMIT)
                                                                : load_count_i[CNT_W-1:0];
    assign w_start  = (r_state == S_IDLE) && start_i;
    // RUN is left on the final accept, so ready never exceeds the count.
    assign w_ready  = (r_state == S_RUN);
    assign w_accept = s_valid_i && w_ready;
    assign w_last   = (r_elem_cnt == (r_count - 1'b1));

    assign s_ready_o = w_ready;
    assign idle_o    = (r_state == S_IDLE);
    assign run_o     = (r_state == S_RUN) || (r_state == S_FLUSH);
    assign done_o    = (r_state == S_DONE);
    assign addr_b0_o = r_addr;
    assign d_b0_o    = r_data;
    assign ce_b0_o   = r_ce;
    assign we_b0_o   = r_ce;

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (start_i) begin
                    w_state_nxt = (w_count_clip == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (w_accept && w_last) begin
                    w_state_nxt = S_FLUSH;
                end
            end
            S_FLUSH: w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Latched element count and running accept count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count    <= '0;
            r_elem_cnt <= '0;
        end else if (w_start) begin
            r_count    <= w_count_clip;
            r_elem_cnt <= '0;
        end else if (w_accept) begin
            r_elem_cnt <= r_elem_cnt + 1'b1;
        end
    end

    lane_packer u_lane_packer (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_clear    (w_start),
        .i_accept   (w_accept),
        .i_last     (w_last),
        .i_data     (s_data_i),
        .o_row_done (w_row_done),
        .o_row_data (w_row_data)
    );

    // BRAM0 port register: one-cycle write strobe per completed row; address
    // and data hold between writes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ce      <= 1'b0;
            r_addr    <= '0;
            r_data    <= '0;
            r_row_cnt <= '0;
        end else begin
            r_ce <= 1'b0;
            if (w_start) begin
                r_row_cnt <= '0;
            end else if (w_row_done) begin
                r_ce      <= 1'b1;
                r_addr    <= r_row_cnt;
                r_data    <= w_row_data;
                r_row_cnt <= r_row_cnt + 1'b1;
            end
        end
    end

`ifdef BRAM0_LOADER_CHECKSUM_EN
    localparam int SUM_W = 2 * IN_DATA_WIDTH;

    logic [SUM_W-1:0] r_sum [LANES];

    // Per-lane wrapping sums; padded lanes never receive an element.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < LANES; i++) r_sum[i] <= '0;
        end else if (w_start) begin
            for (int i = 0; i < LANES; i++) r_sum[i] <= '0;
        end else if (w_accept) begin
            r_sum[r_elem_cnt[$clog2(LANES)-1:0]] <=
                r_sum[r_elem_cnt[$clog2(LANES)-1:0]] + SUM_W'(s_data_i);
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_cksum
        assign checksum_o[g*SUM_W +: SUM_W] = r_sum[g];
    end
`endif

endmodule
`default_nettype wire

// File: doc/bram0_loader.md
# bram0_loader

Stream-to-BRAM0 writer: accepts 8-bit elements over a valid/ready stream, packs four per 32-bit row (first element in the low byte), and writes rows to BRAM0 from address 0 upward. It fills BRAM0 before the accumulate/write-back datapath runs, using the same row layout and the same idle/run/done status style. A final partial row is zero-padded.

## Interface
- CNT_BIT, 31: width of `load_count_i`.
- AWIDTH, 8: BRAM0 address width.
- DWIDTH, 32: BRAM0 row width.
- IN_DATA_WIDTH, 8: element width; LANES = DWIDTH/IN_DATA_WIDTH = 4.

Ports:
- clk  in  1  clock.
- reset_n  in  1  reset, asynchronous, active-low.
- start_i  in  1  start pulse; sampled only in IDLE.
- load_count_i  in  CNT_BIT  number of elements to load; latched on accepted start.
- s_valid_i  in  1  stream element valid.
- s_data_i  in  IN_DATA_WIDTH  stream element.
- s_ready_o  out  1  stream ready; high only in RUN.
- idle_o / run_o / done_o  out  1 each  one-hot state status.
- addr_b0_o  out  AWIDTH  BRAM0 row address.
- ce_b0_o / we_b0_o  out  1 each  chip enable and write enable; always asserted together.
- d_b0_o  out  DWIDTH  row data.
- checksum_o  out  4*2*IN_DATA_WIDTH  per-lane sums; present only with the macro.

## Operation
- States:
  - IDLE: start_i → RUN, or → DONE if the latched count is 0.
  - RUN: the final element is accepted → FLUSH.
  - FLUSH: → DONE.
  - DONE: → IDLE.
- Count handling: load_count_i is clipped to LANES*2^AWIDTH (1024). s_ready_o never exceeds the clipped count.
- Acceptance: an element is accepted when s_valid_i && s_ready_o. It goes into lane index `elem_cnt % LANES`, at bits [8l+7:8l].
- Row write: when lane 3 fills, or the final element is accepted, the row is written.
  - The packed row is copied to registered d_b0_o, addr_b0_o = row_cnt, and ce/we are driven high for exactly the next cycle.
  - row_cnt then increments.
  - The lane buffer is cleared to zero, so partial rows are zero-padded in unused upper lanes.
- Back-to-back: the stream may continue with no bubble while a row write is in flight. The row buffer and the output register are separate.
- Rows written = ceil(N/4), at addresses 0..ceil(N/4)-1, strictly ascending and each written once.
- start_i outside IDLE is ignored. s_valid_i outside RUN is ignored.
- s_data_i may change freely while s_ready_o=0.

## Timing
- Reset values: idle_o=1; all other outputs 0, including addr, d, ce, we and checksum.
- Reset mid-operation returns the block to IDLE immediately with ce/we low. The partial row is discarded.
- Start sampled at edge E: run_o and s_ready_o are high from cycle E+1.
- Element k (0-based), accepted at edge A:
  - If it completes a row, ce/we are high in cycle A+1 with the row data.
  - If it is the final element, the state is FLUSH in cycle A+1 (write asserted), DONE in A+2 (done_o for exactly one cycle), and IDLE in A+3.
- N=0: DONE in E+1, IDLE in E+2, no writes.
- Continuous valid: N accepts take N cycles. Total start-to-done latency is N+2 cycles.
- When not writing, ce_b0_o=we_b0_o=0 and d/addr hold their last value.

## Configuration
- BRAM0_LOADER_CHECKSUM_EN defined:
  - Four per-lane 16-bit sums of accepted elements (zero-padded lanes add 0), wrap modulo 2^16.
  - Packed as {s4,s3,s2,s1} on checksum_o.
  - Cleared on accepted start; valid and held from DONE until the next start.
  - Matches the BRAM1 result row format.
- Undefined: checksum_o port and its adders are absent.

## Structure
- Shared package bram_pkg holds:
  - AWIDTH, DWIDTH, IN_DATA_WIDTH and LANES constants.
  - The state enum {IDLE, RUN, FLUSH, DONE}.
  - The clip-limit constant.
- One sub-module, lane_packer: lane index, row buffer, row-complete pulse and clear. The top level holds the FSM, counters, BRAM port registers and checksum.

## Test plan
- N=8, elements 0x01..0x08, valid held high → row0=0x04030201, row1=0x08070605; writes in cycles A+1 after the 4th and 8th accepts; done 10 cycles after start.
- N=5, elements 0x11..0x15 → row0=0x14131211, row1=0x00000015; exactly 2 writes; no write to addr 2.
- N=0 → done_o high in E+1, ce/we never asserted, idle_o high in E+2.
- N=8 with valid toggling 1-0-1-0 and start_i pulsed mid-RUN → identical row contents to the first test, start ignored, s_ready_o stays 0 after the 8th accept.
- N=1024 and N=2000 → both write addresses 0..255 once each; for 2000, s_ready_o falls after 1024 accepts.
- Checksum build, N=8 of 0xFF → checksum_o=0x01FE01FE01FE01FE. Reset asserted at element 3 → outputs return to reset values and a new start works normally.
